// File: rtl/host_pkg.sv
// Shared constants and types for the simulation host port arbiter.
package host_pkg;

    localparam logic [15:0] PUTCHAR_OFFS = 16'h1000;
    localparam logic [15:0] FINISH_OFFS  = 16'h2000;
    localparam logic [15:0] ADDR_MASK    = 16'hFFFF;

    typedef enum logic {
        ARB_RUN,
        ARB_HALT
    } arb_state_e;

    function automatic logic is_finish(input logic [15:0] addr_lo);
        return (addr_lo & ADDR_MASK) == FINISH_OFFS;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_gnt_o
);

    always_comb begin
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int off = N - 1; off >= 0; off--) begin
            int k;
            k = (int'(ptr_i) + off) % N;
            if (req_i[k]) begin
                gnt_idx_o = IW'(k);
                any_gnt_o = 1'b1;
            end
        end
        gnt_o = any_gnt_o ? (N'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/host_req_arbiter.sv
// Round-robin sharing of the simulation host port, with one register
// stage toward the host and a sticky halt after a finish write.
module host_req_arbiter
    import host_pkg::*;
#(
    parameter  int NUM_REQ_P    = 2,
    parameter  int ADDR_WIDTH_P = 32,
    parameter  int DATA_WIDTH_P = 64,
    localparam int MASK_W       = DATA_WIDTH_P / 8,
    localparam int IDX_W        = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ_P-1:0]              req_i,
    input  logic [NUM_REQ_P-1:0]              we_i,
    input  logic [NUM_REQ_P*ADDR_WIDTH_P-1:0] addr_i,
    input  logic [NUM_REQ_P*DATA_WIDTH_P-1:0] wdata_i,
    input  logic [NUM_REQ_P*MASK_W-1:0]       be_i,
    output logic [NUM_REQ_P-1:0]              gnt_o,
    output logic [NUM_REQ_P-1:0]              rvalid_o,
    output logic [DATA_WIDTH_P-1:0]           rdata_o,
    output logic                              host_req_o,
    output logic                              host_we_o,
    output logic [ADDR_WIDTH_P-1:0]           host_addr_o,
    output logic [DATA_WIDTH_P-1:0]           host_data_o,
    output logic [MASK_W-1:0]                 host_be_o,
    input  logic [DATA_WIDTH_P-1:0]           host_rdata_i,
    output logic                              finished_o
);

    logic [NUM_REQ_P-1:0]    arb_gnt;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    any_gnt;
    logic                    grant;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        ptr_d;
    arb_state_e              state_q;
    logic                    sel_we;
    logic [ADDR_WIDTH_P-1:0] sel_addr;
    logic [DATA_WIDTH_P-1:0] sel_data;
    logic [MASK_W-1:0]       sel_be;
    logic [ADDR_WIDTH_P+15:0] sel_addr_ext;
    logic                    sel_fin;

    logic                    host_req_q;
    logic                    host_we_q;
    logic [ADDR_WIDTH_P-1:0] host_addr_q;
    logic [DATA_WIDTH_P-1:0] host_data_q;
    logic [MASK_W-1:0]       host_be_q;
    logic [NUM_REQ_P-1:0]    rvalid_q;
    logic                    fin_q;

    rr_arbiter #(
        .N(NUM_REQ_P)
    ) u_rr (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .gnt_o    (arb_gnt),
        .gnt_idx_o(gnt_idx),
        .any_gnt_o(any_gnt)
    );

    assign grant = any_gnt && (state_q == ARB_RUN);
    assign gnt_o = (state_q == ARB_RUN) ? arb_gnt : '0;

    always_comb begin
        sel_we       = we_i[gnt_idx];
        sel_addr     = addr_i[int'(gnt_idx)*ADDR_WIDTH_P +: ADDR_WIDTH_P];
        sel_data     = wdata_i[int'(gnt_idx)*DATA_WIDTH_P +: DATA_WIDTH_P];
        sel_be       = be_i[int'(gnt_idx)*MASK_W +: MASK_W];
        sel_addr_ext = {16'h0000, sel_addr};
        sel_fin      = sel_we && is_finish(sel_addr_ext[15:0]);
    end

    always_comb begin
        if (int'(gnt_idx) == NUM_REQ_P - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            state_q     <= ARB_RUN;
            host_req_q  <= 1'b0;
            host_we_q   <= 1'b0;
            host_addr_q <= '0;
            host_data_q <= '0;
            host_be_q   <= '0;
            rvalid_q    <= '0;
            fin_q       <= 1'b0;
        end else begin
            host_req_q <= grant;
            rvalid_q   <= grant ? arb_gnt : '0;
            if (grant) begin
                host_we_q   <= sel_we;
                host_addr_q <= sel_addr;
                host_data_q <= sel_data;
                host_be_q   <= sel_be;
                ptr_q       <= ptr_d;
                if (sel_fin) begin
                    state_q <= ARB_HALT;
                    fin_q   <= 1'b1;
                end
            end
        end
    end

    assign host_req_o  = host_req_q;
    assign host_we_o   = host_we_q;
    assign host_addr_o = host_addr_q;
    assign host_data_o = host_data_q;
    assign host_be_o   = host_be_q;
    assign rvalid_o    = rvalid_q;
    assign finished_o  = fin_q;
    assign rdata_o     = (|rvalid_q) ? host_rdata_i : '0;

endmodule
